sd_spi_engine: RTL and testbench
================================

Name: sd_spi_engine

Overview:
SPI mode-0 byte transceiver that sits directly downstream of the SD controller's 8086 register interface and drives the SD card pins. The register block hands it a TX byte plus a start strobe; the engine shifts it out on MOSI, captures MISO, returns the RX byte and signals completion for status/IRQ. It provides a one-deep TX holding register so the CPU can queue the next byte while the current one shifts. It also provides a selectable slow (init) or fast SCLK rate, and chip-select sequencing.

Parameters:
SLOW_DIV, 24, half-period minus one in clk cycles for init rate (20 MHz clk -> 400 kHz SCLK)
FAST_DIV, 0, half-period minus one for data rate (20 MHz clk -> 10 MHz SCLK)

Ports:
clk  input  1  system clock, 20 MHz
reset  input  1  asynchronous, active-high reset
TX_DATA  input  8  byte to transmit, sampled when START is high
START  input  1  one-clk strobe from register write
FAST  input  1  0 = SLOW_DIV, 1 = FAST_DIV; sampled at byte start
CS_EN  input  1  1 = assert card select
CLR_OVR  input  1  one-clk strobe, clears OVERRUN
MISO  input  1  card data out, already synchronised upstream
RX_DATA  output  8  last received byte
BUSY  output  1  shift in progress or holding register full
DONE  output  1  one-clk pulse per completed byte
OVERRUN  output  1  sticky: START lost because holding register full
SD_CS  output  1  card chip select, active low
SCLK  output  1  SPI clock, idles low
MOSI  output  1  SPI data out, idles high

Behaviour:
- Reset (async, immediate): SD_CS=1, SCLK=0, MOSI=1, BUSY=0, DONE=0, OVERRUN=0, RX_DATA=8'hFF, holding empty, state IDLE.
- States: IDLE, LOW (SCLK low half-period), HIGH (SCLK high half-period).
- Half-period counter: loaded with the divider latched at byte start (FAST ? FAST_DIV : SLOW_DIV). Each half lasts div+1 clk cycles. One byte lasts 16*(div+1) clk cycles from leaving IDLE to DONE.
- IDLE + START at a clk edge: on the next cycle, state=LOW, BUSY=1, shift register=TX_DATA, MOSI=TX_DATA[7], SCLK=0, and the divider is latched.
- LOW, counter expires: state=HIGH, SCLK=1, and MISO is sampled into shift register bit 0 (rising-edge sample).
- HIGH, counter expires, bits remaining: state=LOW, SCLK=0, shift register moves left, MOSI=next bit (falling-edge launch).
- HIGH, counter expires after the 8th bit:
  - SCLK=0.
  - RX_DATA=captured byte.
  - DONE=1 for exactly one clk.
  - If holding is full: load holding into the shift register, latch the divider, MOSI=holding[7], state=LOW, BUSY stays 1, holding becomes empty. No idle gap between bytes.
  - Otherwise: state=IDLE, MOSI=1, BUSY=0 in the same cycle DONE is high.
- START while shifting and holding empty: TX_DATA is captured into holding.
- START while holding full: the byte is dropped and OVERRUN=1.
- START coinciding with the final-bit completion cycle: completion reloads from the old holding first, then the new byte enters holding. No overrun.
- CLR_OVR clears OVERRUN. CLR_OVR in the same cycle as a new overrun leaves OVERRUN=1 (set wins).
- SD_CS follows ~CS_EN one clk later, but only while state is IDLE and holding is empty. A change during a transfer is deferred until the engine goes idle, so CS never toggles mid-byte.
- FAST changes mid-byte take effect at the next byte start only.
- Reset mid-byte: the transfer is aborted, outputs return to reset values, and no DONE is issued.

Decomposition:
- Shared package sd_pkg: state enum (IDLE/LOW/HIGH), SLOW_DIV/FAST_DIV defaults, and the RX reset value 8'hFF, shared with the register block.
- One natural sub-module: sd_clkdiv_cnt, a loadable half-period down-counter with an expire pulse.
- Shift register, holding buffer and CS logic stay in the top.

Test Plan:
1. Slow mode, MISO tied to 1, START with TX_DATA=8'hFF -> MOSI high for all bits; 8 SCLK pulses of 25 clk high / 25 clk low; DONE after 400 clk; RX_DATA=8'hFF; BUSY low with DONE.
2. Fast mode, MISO looped to MOSI, TX_DATA=8'h40 -> SCLK period 2 clk; DONE 16 clk after start; RX_DATA=8'h40; MOSI bit sequence 0,1,0,0,0,0,0,0.
3. Back-to-back: START 8'h40, then START 8'h95 during the first byte -> no idle gap; two DONE pulses 16*(div+1) clk apart; BUSY continuous; OVERRUN=0.
4. Overrun: three STARTs within the first byte -> third byte dropped, OVERRUN=1; CLR_OVR -> OVERRUN=0.
5. CS deferral: CS_EN 1->0 mid-byte -> SD_CS stays 0 until the cycle after BUSY falls, then goes 1; CS_EN 0->1 while idle -> SD_CS=0 one clk later.
6. Reset mid-byte after bit 3 -> SCLK=0, MOSI=1, BUSY=0, RX_DATA=8'hFF immediately; no DONE; a fresh START then completes normally.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD SPI engine and register block.
// State encoding, default clock dividers and the RX reset value.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH
   } sd_state_t;

   localparam int DIV_W        = 8;
   localparam int SLOW_DIV_DEF = 24;
   localparam int FAST_DIV_DEF = 0;

   localparam logic [7:0] RX_RST = 8'hFF;

   function automatic logic [DIV_W-1:0] pick_div(
      input logic fast,
      input int   slow_d,
      input int   fast_d
   );
      return fast ? DIV_W'(fast_d) : DIV_W'(slow_d);
   endfunction

endpackage

// File: rtl/sd_clkdiv_cnt.sv
// Loadable half-period down-counter for the SPI clock.
// expire is high in the last cycle of each half-period.
module sd_clkdiv_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expire
);

   logic [W-1:0] cnt;

   assign expire = en && (cnt == '0);

   // Reload on request, otherwise count down to zero while enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/sd_spi_engine.sv
// SPI mode-0 byte engine with one-deep TX holding register,
// slow/fast SCLK selection and deferred chip-select updates.
module sd_spi_engine
   import sd_pkg::*;
#(
   parameter int SLOW_DIV = SLOW_DIV_DEF,
   parameter int FAST_DIV = FAST_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] TX_DATA,
   input  logic       START,
   input  logic       FAST,
   input  logic       CS_EN,
   input  logic       CLR_OVR,
   input  logic       MISO,
   output logic [7:0] RX_DATA,
   output logic       BUSY,
   output logic       DONE,
   output logic       OVERRUN,
   output logic       SD_CS,
   output logic       SCLK,
   output logic       MOSI
);

   sd_state_t        state;
   logic [7:0]       sh;
   logic [7:0]       hold_q;
   logic             hold_full;
   logic             miso_bit;
   logic [2:0]       bit_cnt;
   logic [DIV_W-1:0] div_q;

   logic [DIV_W-1:0] div_new;
   logic [DIV_W-1:0] load_val;
   logic [7:0]       next_byte;
   logic             expire;
   logic             shifting;
   logic             last;
   logic             start_idle;
   logic             chain;
   logic             new_byte;
   logic             ovr_set;

   // Byte sequencing: when a byte starts, ends, or chains on.
   always_comb begin
      shifting   = (state != IDLE);
      last       = (state == HIGH) && expire && (bit_cnt == 3'd7);
      start_idle = (state == IDLE) && START;
      chain      = last && (hold_full || START);
      new_byte   = start_idle || chain;
      next_byte  = (last && hold_full) ? hold_q : TX_DATA;
      div_new    = pick_div(FAST, SLOW_DIV, FAST_DIV);
      load_val   = new_byte ? div_new : div_q;
      ovr_set    = START && shifting && hold_full && !last;
   end

   sd_clkdiv_cnt #(
      .W(DIV_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .en       (shifting),
      .load     (new_byte || expire),
      .load_val (load_val),
      .expire   (expire)
   );

   // MOSI is the shifter MSB; the shifter idles at all-ones.
   assign MOSI = sh[7];

   // SPI bit engine: sample on SCLK rise, launch on SCLK fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         sh       <= 8'hFF;
         miso_bit <= 1'b1;
         bit_cnt  <= 3'd0;
         div_q    <= '0;
         SCLK     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         RX_DATA  <= RX_RST;
      end else begin
         DONE <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START) begin
                  state   <= LOW;
                  sh      <= TX_DATA;
                  bit_cnt <= 3'd0;
                  div_q   <= div_new;
                  SCLK    <= 1'b0;
                  BUSY    <= 1'b1;
               end
            end
            LOW: begin
               if (expire) begin
                  state    <= HIGH;
                  SCLK     <= 1'b1;
                  miso_bit <= MISO;
               end
            end
            HIGH: begin
               if (expire) begin
                  SCLK <= 1'b0;
                  if (bit_cnt != 3'd7) begin
                     state   <= LOW;
                     sh      <= {sh[6:0], miso_bit};
                     bit_cnt <= bit_cnt + 3'd1;
                  end else begin
                     RX_DATA <= {sh[6:0], miso_bit};
                     DONE    <= 1'b1;
                     if (chain) begin
                        state   <= LOW;
                        sh      <= next_byte;
                        bit_cnt <= 3'd0;
                        div_q   <= div_new;
                     end else begin
                        state <= IDLE;
                        sh    <= 8'hFF;
                        BUSY  <= 1'b0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Holding register and sticky overrun flag (set beats clear).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q    <= 8'h00;
         hold_full <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (last && hold_full) begin
            hold_full <= START;
            if (START) hold_q <= TX_DATA;
         end else if (START && shifting && !hold_full && !last) begin
            hold_full <= 1'b1;
            hold_q    <= TX_DATA;
         end
         if (ovr_set) OVERRUN <= 1'b1;
         else if (CLR_OVR) OVERRUN <= 1'b0;
      end
   end

   // Chip select only moves while fully idle, never mid-byte.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         SD_CS <= 1'b1;
      end else if (state == IDLE && !hold_full) begin
         SD_CS <= ~CS_EN;
      end
   end

endmodule

// File: tb/tb_sd_spi_engine.sv
// Directed bench for sd_spi_engine: vector table for single
// bytes plus hand-written multi-byte, CS and reset sequences.
module tb_sd_spi_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       start;
   logic       fast;
   logic       cs_en;
   logic       clr_ovr;
   logic       miso;
   logic [7:0] rx_data;
   logic       busy;
   logic       done;
   logic       overrun;
   logic       sd_cs;
   logic       sclk;
   logic       mosi;

   logic loop_en;
   logic miso_val;

   int total = 0;
   int bad   = 0;

   assign miso = loop_en ? mosi : miso_val;

   always #5 clk = ~clk;

   sd_spi_engine dut (
      .clk     (clk),
      .reset   (reset),
      .TX_DATA (tx_data),
      .START   (start),
      .FAST    (fast),
      .CS_EN   (cs_en),
      .CLR_OVR (clr_ovr),
      .MISO    (miso),
      .RX_DATA (rx_data),
      .BUSY    (busy),
      .DONE    (done),
      .OVERRUN (overrun),
      .SD_CS   (sd_cs),
      .SCLK    (sclk),
      .MOSI    (mosi)
   );

   typedef struct {
      logic [7:0] tx;
      logic       fast;
      logic       loop;
      logic       mv;
      logic [7:0] exp_rx;
      logic [7:0] exp_mosi;
      int         exp_cyc;
      int         exp_hi;
   } vec_t;

   vec_t vecs[5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic run_byte(input vec_t v);
      int         cyc;
      int         nb;
      int         hi;
      logic       prev;
      logic [7:0] bits;
      loop_en  = v.loop;
      miso_val = v.mv;
      fast     = v.fast;
      tx_data  = v.tx;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      nb    = 0;
      hi    = 0;
      prev  = 1'b0;
      bits  = 8'h00;
      while (!done && cyc < 2000) begin
         if (sclk && !prev) begin
            bits = {bits[6:0], mosi};
            nb++;
         end
         if (sclk) hi++;
         prev = sclk;
         tick();
         cyc++;
      end
      chk("byte_cycles", 32'(cyc), 32'(v.exp_cyc));
      chk("byte_rx", 32'(rx_data), 32'(v.exp_rx));
      chk("byte_mosi_bits", 32'(bits), 32'(v.exp_mosi));
      chk("byte_sclk_pulses", 32'(nb), 32'd8);
      chk("byte_sclk_high", 32'(hi), 32'(v.exp_hi));
      chk("byte_busy_at_done", 32'(busy), 32'd0);
      chk("byte_mosi_idle", 32'(mosi), 32'd1);
      tick();
      chk("byte_done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int         cyc;
      int         d1;
      int         d2;
      int         gap;
      int         dn;
      int         cs_hi;
      int         rises;
      logic       prev;
      logic [7:0] rx1;

      vecs[0] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 400, 200};
      vecs[1] = '{8'h40, 1'b1, 1'b1, 1'b0, 8'h40, 8'h40, 16, 8};
      vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 16, 8};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h3C, 16, 8};
      vecs[4] = '{8'h81, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h81, 16, 8};

      reset    = 1'b1;
      tx_data  = 8'h00;
      start    = 1'b0;
      fast     = 1'b0;
      cs_en    = 1'b0;
      clr_ovr  = 1'b0;
      loop_en  = 1'b0;
      miso_val = 1'b1;
      repeat (2) tick();
      chk("rst_sd_cs", 32'(sd_cs), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);
      chk("rst_rx", 32'(rx_data), 32'hFF);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_byte(vecs[i]);
         tick();
      end

      // back-to-back: second START lands mid-byte
      loop_en = 1'b1;
      fast    = 1'b1;
      tx_data = 8'h40;
      start   = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      d1    = -1;
      d2    = -1;
      gap   = 0;
      rx1   = 8'h00;
      while (d2 < 0 && cyc < 100) begin
         if (cyc == 3) begin
            tx_data = 8'h95;
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            if (d1 < 0) begin
               d1  = cyc;
               rx1 = rx_data;
            end else begin
               d2 = cyc;
            end
         end
         if (!busy && d2 < 0) gap++;
         tick();
         cyc++;
      end
      start = 1'b0;
      chk("b2b_done1", 32'(d1), 32'd16);
      chk("b2b_done2", 32'(d2), 32'd32);
      chk("b2b_rx1", 32'(rx1), 32'h40);
      chk("b2b_rx2", 32'(rx_data), 32'h95);
      chk("b2b_busy_gap", 32'(gap), 32'd0);
      chk("b2b_ovr", 32'(overrun), 32'd0);
      chk("b2b_busy_end", 32'(busy), 32'd0);
      tick();

      // overrun: three STARTs in the first byte
      tx_data = 8'h11;
      start   = 1'b1;
      tick();
      tx_data = 8'h22;
      tick();
      chk("ovr_not_yet", 32'(overrun), 32'd0);
      tx_data = 8'h33;
      tick();
      start = 1'b0;
      chk("ovr_set", 32'(overrun), 32'd1);
      cyc = 0;
      dn  = 0;
      while (dn < 2 && cyc < 100) begin
         if (done) dn++;
         if (dn < 2) begin
            tick();
            cyc++;
         end
      end
      chk("ovr_done_cnt", 32'(dn), 32'd2);
      chk("ovr_rx_last", 32'(rx_data), 32'h22);
      chk("ovr_sticky", 32'(overrun), 32'd1);
      clr_ovr = 1'b1;
      tick();
      clr_ovr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      tick();

      // chip-select deferral
      cs_en = 1'b1;
      tick();
      chk("cs_assert_idle", 32'(sd_cs), 32'd0);
      tx_data = 8'h5A;
      start   = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      cs_hi = 0;
      while (!done && cyc < 100) begin
         if (cyc == 3) cs_en = 1'b0;
         if (sd_cs) cs_hi++;
         tick();
         cyc++;
      end
      chk("cs_held_midbyte", 32'(cs_hi), 32'd0);
      chk("cs_at_done", 32'(sd_cs), 32'd0);
      chk("cs_rx", 32'(rx_data), 32'h5A);
      tick();
      chk("cs_release", 32'(sd_cs), 32'd1);
      cs_en = 1'b1;
      tick();
      chk("cs_reassert", 32'(sd_cs), 32'd0);

      // asynchronous reset in the middle of a slow byte
      loop_en  = 1'b0;
      miso_val = 1'b0;
      fast     = 1'b0;
      tx_data  = 8'h00;
      start    = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      rises = 0;
      prev  = 1'b0;
      while (!(rises == 3 && !sclk) && cyc < 1000) begin
         if (sclk && !prev) rises++;
         prev = sclk;
         tick();
         cyc++;
      end
      chk("rstmid_reached", 32'(rises), 32'd3);
      chk("rstmid_pre_mosi", 32'(mosi), 32'd0);
      #3;
      reset = 1'b1;
      #1;
      chk("rstmid_sclk", 32'(sclk), 32'd0);
      chk("rstmid_mosi", 32'(mosi), 32'd1);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_rx", 32'(rx_data), 32'hFF);
      chk("rstmid_cs", 32'(sd_cs), 32'd1);
      tick();
      reset = 1'b0;
      dn    = 0;
      for (int i = 0; i < 500; i++) begin
         if (done) dn++;
         tick();
      end
      chk("rstmid_no_done", 32'(dn), 32'd0);
      run_byte(vecs[3]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
